// File: rtl/cache_mem_arbiter.sv
// ============================================================================
// cache_mem_arbiter: icache/dcache arbiter onto one shared RAM port.
// Optional statistics counters: define CACHE_ARB_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cache_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              ram_err
`ifdef CACHE_ARB_STATS_EN
  ,
  output logic [15:0]       igrant_cnt,
  output logic [15:0]       dgrant_cnt,
  output logic [7:0]        force_cnt
`endif
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_IGRANT = 2'd1;
  localparam logic [1:0] c_DGRANT = 2'd2;

  localparam logic [1:0] c_RAM_ACCESS = 2'd2;
  localparam logic [1:0] c_RAM_ERROR  = 2'd3;

  localparam logic [3:0] c_STREAK_MAX = 4'(MAX_DSTREAK);

  logic [1:0] state_q, state_d;
  logic [3:0] dstreak_q, dstreak_d;
  logic       ram_err_q, ram_err_d;

  logic w_dreq;
  logic w_force;
  logic w_i_act;
  logic w_d_act;
  logic w_i_done;
  logic w_d_done;
  logic w_err;

  assign w_dreq   = dREN | dWEN;
  // Starvation guard: icache pending and the dcache streak has hit its limit.
  assign w_force  = (state_q == c_IDLE) && iREN && (dstreak_q == c_STREAK_MAX);
  assign w_i_act  = (state_q == c_IGRANT) && iREN;
  assign w_d_act  = (state_q == c_DGRANT) && w_dreq;
  assign w_i_done = w_i_act && (ramstate == c_RAM_ACCESS);
  assign w_d_done = w_d_act && (ramstate == c_RAM_ACCESS);
  assign w_err    = (w_i_act || w_d_act) && (ramstate == c_RAM_ERROR);

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (state_q == c_IGRANT) begin
      ramREN  = iREN;
      ramaddr = iaddr;
    end else if (state_q == c_DGRANT) begin
      ramaddr = daddr;
      if (dWEN) begin
        ramWEN   = 1'b1;
        ramstore = dstore;
      end else begin
        ramREN = dREN;
      end
    end
  end

  assign iwait   = ~w_i_done;
  assign dwait   = ~w_d_done;
  assign iload   = w_i_done ? ramload : '0;
  assign dload   = w_d_done ? ramload : '0;
  assign ram_err = ram_err_q;

  always_comb begin
    state_d   = state_q;
    dstreak_d = dstreak_q;
    ram_err_d = ram_err_q | w_err;
    case (state_q)
      c_IDLE: begin
        if (w_dreq && !w_force) begin
          state_d = c_DGRANT;
        end else if (iREN) begin
          state_d = c_IGRANT;
        end
      end
      c_IGRANT: begin
        if (!iREN || w_i_done || w_err) begin
          state_d = c_IDLE;
        end
      end
      c_DGRANT: begin
        if (!w_dreq || w_d_done || w_err) begin
          state_d = c_IDLE;
        end
      end
      default: state_d = c_IDLE;
    endcase
    if (w_i_done) begin
      dstreak_d = '0;
    end else if (w_d_done) begin
      if (!iREN) begin
        dstreak_d = '0;
      end else if (dstreak_q != c_STREAK_MAX) begin
        dstreak_d = dstreak_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= c_IDLE;
      dstreak_q <= '0;
      ram_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
      ram_err_q <= ram_err_d;
    end
  end

`ifdef CACHE_ARB_STATS_EN
  logic [15:0] igrant_cnt_q;
  logic [15:0] dgrant_cnt_q;
  logic [7:0]  force_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      igrant_cnt_q <= '0;
      dgrant_cnt_q <= '0;
      force_cnt_q  <= '0;
    end else begin
      if (w_i_done) begin
        igrant_cnt_q <= igrant_cnt_q + 16'd1;
      end
      if (w_d_done) begin
        dgrant_cnt_q <= dgrant_cnt_q + 16'd1;
      end
      // Counts only decisions where a pending dcache request was overridden.
      if (w_force && w_dreq && (force_cnt_q != 8'hFF)) begin
        force_cnt_q <= force_cnt_q + 8'd1;
      end
    end
  end

  assign igrant_cnt = igrant_cnt_q;
  assign dgrant_cnt = dgrant_cnt_q;
  assign force_cnt  = force_cnt_q;
`endif

endmodule

`default_nettype wire
